// File: rtl/core_result_fifo_pkg.sv
// core_result_fifo_pkg: shared word type, width constants and pointer-width helper
package core_result_fifo_pkg;
  localparam int CORE_WIDTH = 32;
  typedef logic [CORE_WIDTH-1:0] core_word_t;
  function automatic int ptr_w(input int depth);
    return $clog2(depth < 2 ? 2 : depth) + 1;
  endfunction
endpackage

// File: rtl/core_result_fifo_if.sv
// core_result_fifo_if: core-side push (in_data/in_valid) and consumer-side ready/valid (out_data/out_valid/out_ready)
interface core_result_fifo_if import core_result_fifo_pkg::*; #(
  parameter int WIDTH = $bits(core_word_t)
);
  logic [WIDTH-1:0] in_data;
  logic in_valid;
  logic [WIDTH-1:0] out_data;
  logic out_valid;
  logic out_ready;
  modport master(output in_data, in_valid, out_ready, input out_data, out_valid);
  modport slave(input in_data, in_valid, out_ready, output out_data, out_valid);
endinterface

// File: rtl/core_result_fifo_ram.sv
// core_result_fifo_ram: DEPTH x WIDTH storage, one write port (we/waddr/wdata), one async read port (raddr/rdata), no reset
module core_result_fifo_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/core_result_fifo.sv
// core_result_fifo: fall-through result FIFO absorbing core bursts; drops and counts words on overflow
// Ports: clk, reset (sync, active-high); bus (slave modport: in_data/in_valid in, out_data/out_valid out, out_ready in);
//        level (occupancy 0..DEPTH), full, empty, drop_count (saturating), overflow_sticky (cleared by reset only)
module core_result_fifo import core_result_fifo_pkg::*; #(
  parameter int WIDTH = CORE_WIDTH,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  core_result_fifo_if.slave        bus,
  output logic [ptr_w(DEPTH)-1:0]  level,
  output logic                     full,
  output logic                     empty,
  output logic [CNT_W-1:0]         drop_count,
  output logic                     overflow_sticky
);
  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  logic [PW-1:0] wptr, rptr;
  logic push, pop, drop;
  logic [WIDTH-1:0] rdata;
  // Extra pointer MSB distinguishes full from empty when the address bits match
  always_comb begin
    empty = wptr == rptr;
    full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    pop = !empty && bus.out_ready;
    push = bus.in_valid && (!full || pop);
    drop = bus.in_valid && full && !bus.out_ready;
    bus.out_valid = !empty;
    bus.out_data = empty ? '0 : rdata;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      level <= '0;
      drop_count <= '0;
      overflow_sticky <= 1'b0;
    end else begin
      wptr <= wptr + PW'(push);
      rptr <= rptr + PW'(pop);
      level <= level + PW'(push) - PW'(pop);
      if (drop) begin
        overflow_sticky <= 1'b1;
        if (!(&drop_count)) drop_count <= drop_count + 1'b1;
      end
    end
  end
  always_ff @(posedge clk)
    if (!reset) begin
      assert (!(push && full && !pop));
      assert (level <= PW'(DEPTH));
      assert (bus.out_valid == !empty);
      assert (level == wptr - rptr);
    end
  core_result_fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk(clk),
    .we(push && !reset),
    .waddr(wptr[AW-1:0]),
    .wdata(bus.in_data),
    .raddr(rptr[AW-1:0]),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_core_result_fifo.sv
// tb_core_result_fifo: directed and random stimulus checked against a queue model; CNT_W=4 twin checks saturation
module tb_core_result_fifo;
  import core_result_fifo_pkg::*;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  core_result_fifo_if #(.WIDTH(32)) a_if();
  core_result_fifo_if #(.WIDTH(32)) b_if();
  assign b_if.in_data = a_if.in_data;
  assign b_if.in_valid = a_if.in_valid;
  assign b_if.out_ready = a_if.out_ready;
  logic [3:0] lvl, lvl_b;
  logic full, empty, sticky, full_b, empty_b, sticky_b;
  logic [15:0] dc;
  logic [3:0] dc_b;
  core_result_fifo #(.WIDTH(32), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(a_if.slave), .level(lvl), .full(full), .empty(empty),
    .drop_count(dc), .overflow_sticky(sticky)
  );
  core_result_fifo #(.WIDTH(32), .DEPTH(DEPTH), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .bus(b_if.slave), .level(lvl_b), .full(full_b), .empty(empty_b),
    .drop_count(dc_b), .overflow_sticky(sticky_b)
  );
  int total = 0;
  int bad = 0;
  logic [31:0] q[$];
  int drops = 0;
  int drops4 = 0;
  bit msticky = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic r);
    bit pop, push, drop, isfull;
    a_if.in_valid = v;
    a_if.in_data = d;
    a_if.out_ready = r;
    #1;
    chk("out_valid", 64'(a_if.out_valid), 64'(q.size() > 0));
    chk("out_data", 64'(a_if.out_data), 64'(q.size() > 0 ? q[0] : 32'd0));
    chk("level", 64'(lvl), 64'(q.size()));
    chk("full", 64'(full), 64'(q.size() == DEPTH));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    chk("drop_count", 64'(dc), 64'(drops));
    chk("drop_count4", 64'(dc_b), 64'(drops4));
    chk("sticky", 64'(sticky), 64'(msticky));
    if (reset) begin
      q.delete();
      drops = 0;
      drops4 = 0;
      msticky = 0;
    end else begin
      isfull = q.size() == DEPTH;
      pop = q.size() > 0 && r;
      push = v && (!isfull || pop);
      drop = v && isfull && !r;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(d);
      if (drop) begin
        msticky = 1;
        if (drops < 65535) drops++;
        if (drops4 < 15) drops4++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b1, 32'hbad0bad0, 1'b1);
    reset = 1'b0;
  endtask

  initial begin
    a_if.in_valid = 1'b0;
    a_if.in_data = '0;
    a_if.out_ready = 1'b0;
    @(negedge clk);
    step(1'b0, 32'd0, 1'b0);
    do_reset();
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_out_data", 64'(a_if.out_data), 64'd0);
    step(1'b1, 32'hA, 1'b0);
    step(1'b1, 32'hB, 1'b0);
    step(1'b1, 32'hC, 1'b0);
    chk("abc_level", 64'(lvl), 64'd3);
    chk("abc_head", 64'(a_if.out_data), 64'hA);
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b1);
    chk("abc_empty", 64'(empty), 64'd1);
    do_reset();
    step(1'b1, 32'h1234, 1'b0);
    chk("fwft_valid", 64'(a_if.out_valid), 64'd1);
    chk("fwft_data", 64'(a_if.out_data), 64'h1234);
    step(1'b0, 32'd0, 1'b1);
    chk("fwft_level", 64'(lvl), 64'd0);
    do_reset();
    for (int i = 1; i <= 10; i++) step(1'b1, 32'(i), 1'b0);
    chk("ovf_full", 64'(full), 64'd1);
    chk("ovf_drops", 64'(dc), 64'd2);
    chk("ovf_sticky", 64'(sticky), 64'd1);
    for (int i = 1; i <= 8; i++) begin
      chk("ovf_drain", 64'(a_if.out_data), 64'(i));
      step(1'b0, 32'd0, 1'b1);
    end
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 32'h100 + 32'(i), 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("pp_head", 64'(a_if.out_data), 64'h100 + 64'(i));
      step(1'b1, 32'h200 + 32'(i), 1'b1);
    end
    chk("pp_level", 64'(lvl), 64'd8);
    chk("pp_drops", 64'(dc), 64'd0);
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 32'h300 + 32'(i), 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 32'h400 + 32'(i), 1'b0);
    chk("sat4", 64'(dc_b), 64'd15);
    chk("sat16", 64'(dc), 64'd20);
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b1);
    chk("pre_rst_level", 64'(lvl), 64'd5);
    chk("pre_rst_sticky", 64'(sticky), 64'd1);
    do_reset();
    chk("mid_rst_level", 64'(lvl), 64'd0);
    chk("mid_rst_empty", 64'(empty), 64'd1);
    chk("mid_rst_data", 64'(a_if.out_data), 64'd0);
    chk("mid_rst_drops", 64'(dc), 64'd0);
    chk("mid_rst_sticky", 64'(sticky), 64'd0);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else if ((i / 100) % 2 == 0) step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 3) == 0));
      else step(1'($urandom_range(0, 3) == 0), $urandom, 1'($urandom_range(0, 3) != 0));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
